// File: rtl/sram_controller_if.sv
// -----------------------------------------------------------------------------
// sram_controller_if
//
// Bundles the signals between the MEM pipeline stage, the SRAM controller and
// the external 16-bit asynchronous SRAM.
//
//   Pipeline side
//     mem_read    load request, held stable while ready=0
//     mem_write   store request, held stable while ready=0
//     addr[31:0]  byte address; bits [18:2] select the 32-bit word
//     wdata[31:0] store data
//     rdata[31:0] registered load data
//     ready       MEM stage may advance (low freezes the pipeline)
//
//   SRAM side
//     sram_addr[17:0]   half-word address {word, half}
//     sram_dq_out[15:0] write data half-word
//     sram_dq_in[15:0]  read data half-word
//     sram_dq_oe        controller drives sram_dq_out
//     sram_we_n         active-low write strobe
//     sram_oe_n         active-low output enable
//
// Modports: slave = the controller, master = pipeline stage plus SRAM device.
// -----------------------------------------------------------------------------
interface sram_controller_if;

    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;

    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic [15:0] sram_dq_in;
    logic        sram_dq_oe;
    logic        sram_we_n;
    logic        sram_oe_n;

    modport slave (
        input  mem_read,
        input  mem_write,
        input  addr,
        input  wdata,
        input  sram_dq_in,
        output rdata,
        output ready,
        output sram_addr,
        output sram_dq_out,
        output sram_dq_oe,
        output sram_we_n,
        output sram_oe_n
    );

    modport master (
        output mem_read,
        output mem_write,
        output addr,
        output wdata,
        output sram_dq_in,
        input  rdata,
        input  ready,
        input  sram_addr,
        input  sram_dq_out,
        input  sram_dq_oe,
        input  sram_we_n,
        input  sram_oe_n
    );

endinterface

// File: rtl/sram_controller.sv
// -----------------------------------------------------------------------------
// sram_controller
//
// Turns one 32-bit MEM-stage load or store into two consecutive accesses of
// a 16-bit asynchronous SRAM: the low half-word first (phase LO), then the
// high half-word (phase HI). Each phase lasts WAIT_CYCLES clock cycles. The
// pipeline is stalled (ready=0) until the one-cycle DONE state, so a request
// costs 2*WAIT_CYCLES+1 cycles from its first appearance to ready.
//
// Parameters
//   WAIT_CYCLES  clock cycles per half-word phase, legal range 2..15
//
// Ports
//   clk  pipeline clock, all state changes on the rising edge
//   rst  synchronous active-high reset
//   bus  sram_controller_if.slave (pipeline request/response + SRAM pins)
//
// All SRAM pins come straight from flops. They are loaded with the values for
// the cycle that is about to start, so the pins change cleanly on the clock
// edge that moves the FSM. ready is the only combinational output because the
// pipeline must see it in the same cycle a request appears.
// -----------------------------------------------------------------------------
module sram_controller #(
    parameter int WAIT_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst,
    sram_controller_if.slave  bus
);

    // Value of cnt in the final cycle of a phase.
    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        LO,
        HI,
        DONE
    } state_t;

    // Everything that goes to the SRAM pins, registered as one bundle.
    typedef struct packed {
        logic [17:0] addr;
        logic [15:0] dq_out;
        logic        dq_oe;
        logic        we_n;
        logic        oe_n;
    } pins_t;

    // Quiescent pin state for IDLE and DONE: strobes inactive, bus released,
    // address and data parked at zero.
    localparam pins_t IDLE_PINS = '{
        addr:   18'h0,
        dq_out: 16'h0,
        dq_oe:  1'b0,
        we_n:   1'b1,
        oe_n:   1'b1
    };

    state_t      state;
    logic [3:0]  cnt;
    logic        write_op;   // latched access type, 1 = store
    logic [31:0] rdata;
    pins_t       pins;

    logic        request;
    logic        write_req;
    logic [16:0] word_addr;
    logic        unused_addr_bits;

    assign request   = bus.mem_read || bus.mem_write;
    // A simultaneous load and store is treated as a load: the SRAM contents
    // are never touched by an ambiguous request.
    assign write_req = bus.mem_write && !bus.mem_read;
    assign word_addr = bus.addr[18:2];

    // Upper address bits and the byte offset play no part in the mapping.
    assign unused_addr_bits = ^{bus.addr[31:19], bus.addr[1:0]};

    // -------------------------------------------------------------------------
    // Pin values for one cycle of an active phase.
    //   half       0 = low half-word (LO), 1 = high half-word (HI)
    //   phase_cnt  position of the cycle inside its phase
    // A store pulses we_n low for all but the last cycle of the phase, which
    // gives the SRAM a data hold cycle with dq still driven.
    // -------------------------------------------------------------------------
    function automatic pins_t phase_pins(
        input logic        is_write,
        input logic        half,
        input logic [3:0]  phase_cnt,
        input logic [16:0] word,
        input logic [31:0] data
    );
        pins_t p;
        p.addr   = {word, half};
        p.dq_out = is_write ? (half ? data[31:16] : data[15:0]) : 16'h0;
        p.dq_oe  = is_write;
        p.we_n   = !(is_write && (phase_cnt != LAST_CNT));
        p.oe_n   = is_write;
        return p;
    endfunction

    // -------------------------------------------------------------------------
    // FSM, phase counter, read data and registered SRAM pins.
    // The request inputs are held stable by the pipeline for the whole access,
    // so addr and wdata can be used directly in every phase.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments throughout, so every branch below
        // sees the pre-edge values of state, cnt and write_op.
        if (rst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            write_op <= 1'b0;
            rdata    <= 32'h0;
            pins     <= IDLE_PINS;
        end else begin
            case (state)
                IDLE: begin
                    if (request) begin
                        state    <= LO;
                        cnt      <= 4'd0;
                        write_op <= write_req;
                        pins     <= phase_pins(write_req, 1'b0, 4'd0,
                                               word_addr, bus.wdata);
                    end else begin
                        pins     <= IDLE_PINS;
                    end
                end

                LO: begin
                    if (cnt == LAST_CNT) begin
                        state <= HI;
                        cnt   <= 4'd0;
                        // The SRAM has had a full phase to settle its output.
                        if (!write_op) begin
                            rdata[15:0] <= bus.sram_dq_in;
                        end
                        pins  <= phase_pins(write_op, 1'b1, 4'd0,
                                            word_addr, bus.wdata);
                    end else begin
                        cnt   <= cnt + 4'd1;
                        pins  <= phase_pins(write_op, 1'b0, cnt + 4'd1,
                                            word_addr, bus.wdata);
                    end
                end

                HI: begin
                    if (cnt == LAST_CNT) begin
                        state <= DONE;
                        cnt   <= 4'd0;
                        if (!write_op) begin
                            rdata[31:16] <= bus.sram_dq_in;
                        end
                        pins  <= IDLE_PINS;
                    end else begin
                        cnt   <= cnt + 4'd1;
                        pins  <= phase_pins(write_op, 1'b1, cnt + 4'd1,
                                            word_addr, bus.wdata);
                    end
                end

                DONE: begin
                    // The pipeline advances during DONE, so whatever request
                    // is visible next cycle is a new one and starts afresh
                    // from IDLE.
                    state <= IDLE;
                    pins  <= IDLE_PINS;
                end

                default: begin
                    state <= IDLE;
                    cnt   <= 4'd0;
                    pins  <= IDLE_PINS;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // ready: high in DONE, or in IDLE with nothing requested. The cycle in
    // which a request first appears is already a stall cycle. While rst is
    // high the FSM is treated as IDLE regardless of its current state.
    // -------------------------------------------------------------------------
    assign bus.ready = (rst || state == IDLE) ? !request : (state == DONE);

    assign bus.rdata       = rdata;
    assign bus.sram_addr   = pins.addr;
    assign bus.sram_dq_out = pins.dq_out;
    assign bus.sram_dq_oe  = pins.dq_oe;
    assign bus.sram_we_n   = pins.we_n;
    assign bus.sram_oe_n   = pins.oe_n;

endmodule

// File: tb/tb_sram_controller.sv
// -----------------------------------------------------------------------------
// tb_sram_controller
//
// Three controllers (WAIT_CYCLES = 3, 2, 15) share one stimulus source and one
// behavioural SRAM; sel chooses which controller receives requests and drives
// the SRAM. Expected behaviour comes from a word-level reference: a memory of
// 32-bit words, the last loaded word per controller, and the cycle timeline
// of an access (cycle 0 request, cycles 1..W low half, W+1..2W high half,
// cycle 2W+1 ready).
// -----------------------------------------------------------------------------
module tb_sram_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  sel;
    logic        req_read;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    int compared   = 0;
    int mismatched = 0;

    int wait_cycles [3] = '{3, 2, 15};

    sram_controller_if bus3 ();
    sram_controller_if bus2 ();
    sram_controller_if bus15 ();

    logic [15:0] dq_in;

    assign bus3.mem_read   = (sel == 2'd0) && req_read;
    assign bus3.mem_write  = (sel == 2'd0) && req_write;
    assign bus3.addr       = req_addr;
    assign bus3.wdata      = req_wdata;
    assign bus3.sram_dq_in = dq_in;

    assign bus2.mem_read   = (sel == 2'd1) && req_read;
    assign bus2.mem_write  = (sel == 2'd1) && req_write;
    assign bus2.addr       = req_addr;
    assign bus2.wdata      = req_wdata;
    assign bus2.sram_dq_in = dq_in;

    assign bus15.mem_read   = (sel == 2'd2) && req_read;
    assign bus15.mem_write  = (sel == 2'd2) && req_write;
    assign bus15.addr       = req_addr;
    assign bus15.wdata      = req_wdata;
    assign bus15.sram_dq_in = dq_in;

    sram_controller #(.WAIT_CYCLES(3))  dut3  (.clk(clk), .rst(rst), .bus(bus3));
    sram_controller #(.WAIT_CYCLES(2))  dut2  (.clk(clk), .rst(rst), .bus(bus2));
    sram_controller #(.WAIT_CYCLES(15)) dut15 (.clk(clk), .rst(rst), .bus(bus15));

    // Outputs of the selected controller.
    logic        o_ready;
    logic [31:0] o_rdata;
    logic [17:0] o_addr;
    logic [15:0] o_dq;
    logic        o_dq_oe;
    logic        o_we_n;
    logic        o_oe_n;

    always_comb begin
        o_ready = bus3.ready;
        o_rdata = bus3.rdata;
        o_addr  = bus3.sram_addr;
        o_dq    = bus3.sram_dq_out;
        o_dq_oe = bus3.sram_dq_oe;
        o_we_n  = bus3.sram_we_n;
        o_oe_n  = bus3.sram_oe_n;
        case (sel)
            2'd1: begin
                o_ready = bus2.ready;
                o_rdata = bus2.rdata;
                o_addr  = bus2.sram_addr;
                o_dq    = bus2.sram_dq_out;
                o_dq_oe = bus2.sram_dq_oe;
                o_we_n  = bus2.sram_we_n;
                o_oe_n  = bus2.sram_oe_n;
            end
            2'd2: begin
                o_ready = bus15.ready;
                o_rdata = bus15.rdata;
                o_addr  = bus15.sram_addr;
                o_dq    = bus15.sram_dq_out;
                o_dq_oe = bus15.sram_dq_oe;
                o_we_n  = bus15.sram_we_n;
                o_oe_n  = bus15.sram_oe_n;
            end
            default: ;
        endcase
    end

    // Behavioural SRAM: writes while we_n is low and the bus is driven,
    // reads combinationally while oe_n is low. A preload port fills it
    // directly from the bench.
    logic [15:0] sram_mem [0:262143];
    logic        preload_en;
    logic [17:0] preload_addr;
    logic [15:0] preload_data;

    always @(posedge clk) begin
        if (preload_en)
            sram_mem[preload_addr] <= preload_data;
        else if (!o_we_n && o_dq_oe)
            sram_mem[o_addr] <= o_dq;
    end

    assign dq_in = o_oe_n ? 16'h0 : sram_mem[o_addr];

    // Word-level reference.
    logic [31:0] ref_mem [int];
    logic [31:0] exp_rdata [3];

    function automatic logic [31:0] ref_word(input int k);
        return ref_mem.exists(k) ? ref_mem[k] : 32'h0;
    endfunction

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic check_idle_pins(input string tag);
        check($sformatf("%s.addr", tag),  32'(o_addr),  32'h0);
        check($sformatf("%s.dq", tag),    32'(o_dq),    32'h0);
        check($sformatf("%s.dq_oe", tag), 32'(o_dq_oe), 32'h0);
        check($sformatf("%s.we_n", tag),  32'(o_we_n),  32'h1);
        check($sformatf("%s.oe_n", tag),  32'(o_oe_n),  32'h1);
    endtask

    task automatic preload_half(input logic [17:0] a, input logic [15:0] d);
        preload_en   = 1'b1;
        preload_addr = a;
        preload_data = d;
        @(posedge clk);
        #1;
        preload_en   = 1'b0;
    endtask

    task automatic preload_word(input logic [16:0] word, input logic [31:0] d);
        preload_half({word, 1'b0}, d[15:0]);
        preload_half({word, 1'b1}, d[31:16]);
        ref_mem[int'(word)] = d;
    endtask

    // No requests for n cycles: ready high and all strobes inactive.
    task automatic idle_cycles(input string tag, input int n);
        req_read  = 1'b0;
        req_write = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check($sformatf("%s.ready", tag), 32'(o_ready), 32'h1);
            check_idle_pins(tag);
            @(posedge clk);
            #1;
        end
    endtask

    // One complete access on the selected controller, checked cycle by cycle.
    // Entered just after a rising edge; returns just after the rising edge
    // that ends the ready cycle, with the request still applied.
    task automatic do_access(input string tag, input logic rd, input logic wr,
                             input logic [31:0] a, input logic [31:0] wd);
        int          w;
        int          half;
        int          pos;
        logic        is_write;
        logic [16:0] word;
        string       ct;
        w        = wait_cycles[sel];
        is_write = wr && !rd;
        word     = a[18:2];
        req_read  = rd;
        req_write = wr;
        req_addr  = a;
        req_wdata = wd;
        for (int c = 0; c <= 2 * w + 1; c++) begin
            @(negedge clk);
            ct = $sformatf("%s.c%0d", tag, c);
            if (c == 2 * w + 1) begin
                if (is_write)
                    ref_mem[int'(word)] = wd;
                else
                    exp_rdata[sel] = ref_word(int'(word));
                check($sformatf("%s.ready", ct), 32'(o_ready), 32'h1);
                check($sformatf("%s.rdata", ct), o_rdata, exp_rdata[sel]);
                check_idle_pins(ct);
            end else if (c == 0) begin
                check($sformatf("%s.ready", ct), 32'(o_ready), 32'h0);
                check($sformatf("%s.rdata", ct), o_rdata, exp_rdata[sel]);
                check_idle_pins(ct);
            end else begin
                half = (c - 1) / w;
                pos  = (c - 1) % w;
                check($sformatf("%s.ready", ct), 32'(o_ready), 32'h0);
                check($sformatf("%s.addr", ct), 32'(o_addr),
                      32'({word, half[0]}));
                if (is_write) begin
                    check($sformatf("%s.dq", ct), 32'(o_dq),
                          32'((half == 1) ? wd[31:16] : wd[15:0]));
                    check($sformatf("%s.dq_oe", ct), 32'(o_dq_oe), 32'h1);
                    check($sformatf("%s.we_n", ct), 32'(o_we_n),
                          (pos == w - 1) ? 32'h1 : 32'h0);
                    check($sformatf("%s.oe_n", ct), 32'(o_oe_n), 32'h1);
                end else begin
                    check($sformatf("%s.dq_oe", ct), 32'(o_dq_oe), 32'h0);
                    check($sformatf("%s.we_n", ct), 32'(o_we_n), 32'h1);
                    check($sformatf("%s.oe_n", ct), 32'(o_oe_n), 32'h0);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        int          op;
        int          w;

        rst          = 1'b1;
        sel          = 2'd0;
        req_read     = 1'b0;
        req_write    = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        preload_en   = 1'b0;
        preload_addr = 18'h0;
        preload_data = 16'h0;
        for (int i = 0; i < 3; i++) exp_rdata[i] = 32'h0;

        // Reset state, and ready following the IDLE rule while rst is high.
        @(posedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst.ready_no_req", 32'(o_ready), 32'h1);
        check("rst.rdata", o_rdata, 32'h0);
        check_idle_pins("rst");
        req_write = 1'b1;
        #1;
        check("rst.ready_req", 32'(o_ready), 32'h0);
        req_write = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // SRAM contents: random words 0..15 plus the directed read pattern.
        for (int k = 0; k < 16; k++) preload_word(17'(k), $urandom);
        preload_word(17'h101, 32'hABCD_1234);

        // Directed read, then back-to-back write and read of the same word.
        do_access("read404", 1'b1, 1'b0, 32'h0000_0404, 32'h0);
        check("read404.word", o_rdata, 32'hABCD_1234);
        do_access("write404", 1'b0, 1'b1, 32'h0000_0404, 32'hDEAD_BEEF);
        check("write404.sram_lo", 32'(sram_mem[18'h202]), 32'h0000_BEEF);
        check("write404.sram_hi", 32'(sram_mem[18'h203]), 32'h0000_DEAD);
        check("write404.rdata_kept", o_rdata, 32'hABCD_1234);
        do_access("readback", 1'b1, 1'b0, 32'h0000_0404, 32'h0);
        check("readback.word", o_rdata, 32'hDEAD_BEEF);

        // Read and write together is a read; ignored address bits set.
        do_access("conflict", 1'b1, 1'b1, 32'hFFF8_0407, 32'h5555_AAAA);
        check("conflict.sram_lo", 32'(sram_mem[18'h202]), 32'h0000_BEEF);
        idle_cycles("idle20", 20);

        // Random traffic with random idle gaps.
        for (int n = 0; n < 60; n++) begin
            a       = $urandom;
            a[18:2] = 17'($urandom_range(0, 15));
            d       = $urandom;
            op      = $urandom_range(0, 2);
            do_access($sformatf("rnd%0d", n), op != 1, op != 0, a, d);
            idle_cycles($sformatf("gap%0d", n), $urandom_range(0, 2));
        end

        // Reset during the HI phase of a write, request held throughout.
        do_access("pre_rst", 1'b1, 1'b0, 32'h0000_0404, 32'h0);
        w         = wait_cycles[0];
        req_read  = 1'b0;
        req_write = 1'b1;
        req_addr  = 32'h0000_0808;
        req_wdata = $urandom;
        repeat (w + 1) @(posedge clk);
        #1;
        @(negedge clk);
        check("midrst.in_hi", 32'(o_addr[0]), 32'h1);
        rst = 1'b1;
        #1;
        check("midrst.ready_during_rst", 32'(o_ready), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) exp_rdata[i] = 32'h0;
        do_access("restart", 1'b0, 1'b1, 32'h0000_0808, req_wdata);
        do_access("restart_rd", 1'b1, 1'b0, 32'h0000_0808, 32'h0);
        idle_cycles("post_rst", 2);

        // Shorter and longer phases: latency 5 and 31.
        sel = 2'd1;
        do_access("w2_write", 1'b0, 1'b1, 32'h0000_000C, 32'h1357_9BDF);
        do_access("w2_read", 1'b1, 1'b0, 32'h0000_000C, 32'h0);
        check("w2_read.word", o_rdata, 32'h1357_9BDF);
        idle_cycles("w2_idle", 2);

        sel = 2'd2;
        do_access("w15_write", 1'b0, 1'b1, 32'h0000_0010, 32'h2468_ACE0);
        do_access("w15_read", 1'b1, 1'b0, 32'h0000_0010, 32'h0);
        check("w15_read.word", o_rdata, 32'h2468_ACE0);
        idle_cycles("w15_idle", 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
